ssds_scan_driver: RTL
=====================

# ssds_scan_driver

Multiplexed driver for a bank of seven-segment displays sharing one segment bus. It scans `DIGITS` hex nibbles plus decimal points onto the displays in a time-multiplexed way. It sits between the register/bus layer, which supplies `value`, and the board pins. It adds scan timing, anti-ghosting blanking, leading-zero suppression, tear-free frame latching and a frame-done pulse.

## Interface
- `DIGITS`, 4: number of displays; legal range 1..8.
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be at least 2.
- `BLANK_CYCLES`, 16: dead cycles at the start of each slot, during which all selects are inactive; legal range 1..SCAN_DIV-1.
- `SEG_ACTIVE_LOW`, 0: when 1, `segments` and `dp` are inverted at the output.
- `SEL_ACTIVE_LOW`, 0: when 1, `select` is inverted at the output.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, all outputs are forced inactive; counters keep running.
- `value` in 4*DIGITS: the nibbles to display; digit i is `value[4i+3:4i]`, and digit 0 is the rightmost, least significant digit.
- `dots` in DIGITS: decimal point for each digit.
- `blank_zeros` in 1: leading-zero suppression enable.
- `segments` out 7: glyph bits, bit6=g down to bit0=a.
- `dp` out 1: decimal point of the selected digit.
- `select` out DIGITS: one-hot digit enable.
- `frame_done` out 1: one-cycle pulse on each shadow load.

## Operation
- **Prescaler.** `presc` counts 0..SCAN_DIV-1 and wraps to 0.
- **Digit index.** On the wrap, `idx` advances 0..DIGITS-1 and wraps to 0.
- **Widths.** `presc` is `$clog2(SCAN_DIV)` bits; `idx` is `max(1,$clog2(DIGITS))` bits.
- **Frame start.** A frame start is `presc==0 && idx==0`.
  - On that cycle, shadow registers load `value`, `dots` and `blank_zeros`.
  - Frame start occurs on the first cycle after reset release, so the first frame shows the live inputs.
- **Display source.** Display data comes only from the shadow registers, so input changes mid-frame never tear the display.
- **Slot phases.**
  - Blank phase: `presc < BLANK_CYCLES`, all selects inactive.
  - Drive phase: otherwise, `select[idx]` is active.
- **Glyph decode (hex).**
  - 0→0111111, 1→0000110, 2→1011011, 3→1001111, 4→1100110, 5→1101101, 6→1111101, 7→0000111.
  - 8→1111111, 9→1101111, A→1110111, b→1111100, C→0111001, d→1011110, E→1111001, F→1110001.
- **Leading-zero suppression.** Digit i (i>0) is blanked when shadow `blank_zeros` is set and shadow nibbles i..DIGITS-1 are all zero.
  - A blanked digit has `segments` = 0000000, but its `dp` is still shown.
  - Digit 0 is never blanked.
- **Enable low.** `select`, `segments` and `dp` are inactive. `frame_done` still pulses and shadow loads still occur.
- **Output polarity.** Inversion per the polarity parameters is applied last. "Inactive" means logical 0 before inversion.

## Timing
- **Registered outputs.** All outputs are registered and are computed from the pre-edge `presc`, `idx` and shadow values, giving 1 cycle latency.
- **Shadow load vs. output.** The shadow load and the output register update on the same edge. The edge that uses the stale shadow value always falls in the blank phase (BLANK_CYCLES≥1), so this is hazard-free.
- **Slot length.** `select[i]` is active for SCAN_DIV-BLANK_CYCLES consecutive cycles per slot.
- **Frame length.** A frame is DIGITS*SCAN_DIV cycles. `frame_done` is high for exactly one cycle per frame, in the cycle after the shadow load.
- **Reset.** `rst_n` low asynchronously clears:
  - `presc`, `idx`, shadows and `frame_done` to 0;
  - `select`, `segments` and `dp` to inactive levels, i.e. polarity-adjusted zeros.
  - After reset release, scanning restarts at digit 0 with a fresh frame.
  - The same applies to a reset asserted mid-slot or mid-frame.
- **DIGITS=1.** `idx` stays 0, every slot is a frame start, and `frame_done` pulses every SCAN_DIV cycles.

## Structure
- **Package `ssds_pkg`.** Holds:
  - the function `ssds_glyph(nibble)` returning 7 bits (the table above);
  - the constants `SSDS_SEG_BLANK` = 7'b0000000 and `SSDS_MAX_DIGITS` = 8.
- **Sub-module `ssds_scan_timer`.** Contains the prescaler and digit index, and outputs `idx`, `frame_start` and `drive_phase`.
- **Top level.** Holds the shadow registers, the zero-suppression prefix logic, glyph selection and the output registers.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2 unless stated otherwise.
- **Reset and first slot.** Hold `rst_n` low, then release.
  - While low, all outputs are 0.
  - `select`=0001 is active from the 3rd through the 8th rising edge after release; edge 9 is blank.
  - `frame_done` is high after edge 1 only, then again 32 cycles later.
- **Glyph mapping.** Set `value`=16'h12AF and `dots`=4'b0100.
  - The slots show digit0 1110001, digit1 1110111, digit2 1011011 with `dp`=1, and digit3 0000110.
- **Leading-zero suppression.** Set `blank_zeros`=1.
  - With `value`=16'h0040: digits 3 and 2 show 0000000, digit1 shows 1100110, digit0 shows 0111111.
  - With `value`=0: only digit0 is lit.
- **Tear-free latch.** Change `value` from 16'h1111 to 16'h2222 during digit 1 of a frame.
  - Digits 2 and 3 of that frame still show 0000110.
  - The next frame shows 1011011 on all digits.
- **Polarity and enable.** Set SEG_ACTIVE_LOW=1 and SEL_ACTIVE_LOW=1.
  - Digit 8 drives `segments`=0000000 with `select`=1110.
  - With `enable`=0, `select`=1111, `segments`=1111111, `dp`=1, and `frame_done` keeps pulsing.
- **Reset mid-scan.** Assert `rst_n` during digit 2's drive phase.
  - Outputs go inactive in the same cycle, without waiting for an edge.
  - After release, digit 0 is driven from the 3rd edge.

Source files
------------

// File: rtl/ssds_pkg.sv
// Shared constants and the hex-to-seven-segment glyph table for the scan driver.
package ssds_pkg;

    localparam logic [6:0] SSDS_SEG_BLANK  = 7'b0000000;
    localparam int         SSDS_MAX_DIGITS = 8;

    // Bit 6 = g down to bit 0 = a.
    function automatic logic [6:0] ssds_glyph(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'h0:    g = 7'b0111111;
            4'h1:    g = 7'b0000110;
            4'h2:    g = 7'b1011011;
            4'h3:    g = 7'b1001111;
            4'h4:    g = 7'b1100110;
            4'h5:    g = 7'b1101101;
            4'h6:    g = 7'b1111101;
            4'h7:    g = 7'b0000111;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1101111;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b1111100;
            4'hC:    g = 7'b0111001;
            4'hD:    g = 7'b1011110;
            4'hE:    g = 7'b1111001;
            default: g = 7'b1110001;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/ssds_scan_timer.sv
// Slot prescaler and digit index; flags the frame start and the drive half of each slot.
module ssds_scan_timer #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int IW           = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [IW-1:0] o_idx,
    output logic          o_frame_start,
    output logic          o_drive_phase
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] r_presc;
    logic [IW-1:0] r_idx;
    logic          w_presc_wrap;
    logic          w_idx_wrap;

    assign w_presc_wrap = (r_presc == PW'(SCAN_DIV - 1));
    assign w_idx_wrap   = (r_idx == IW'(DIGITS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_presc_wrap) begin
            r_presc <= '0;
            r_idx   <= w_idx_wrap ? '0 : r_idx + IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign o_idx         = r_idx;
    assign o_frame_start = (r_presc == '0) && (r_idx == '0);
    assign o_drive_phase = (r_presc >= PW'(BLANK_CYCLES));

endmodule

// File: rtl/ssds_scan_driver.sv
// Multiplexed seven-segment scan driver: frame-latched shadows, leading-zero
// suppression and registered, polarity-adjusted pin outputs.
module ssds_scan_driver
    import ssds_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dots,
    input  logic                  i_blank_zeros,
    output logic [6:0]            o_segments,
    output logic                  o_dp,
    output logic [DIGITS-1:0]     o_select,
    output logic                  o_frame_done
);

    localparam int   IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
    localparam logic SEL_POL = (SEL_ACTIVE_LOW != 0);

    logic [IW-1:0]         w_idx;
    logic                  w_frame_start;
    logic                  w_drive_phase;

    logic [4*DIGITS-1:0]   r_sh_value;
    logic [DIGITS-1:0]     r_sh_dots;
    logic                  r_sh_bz;

    logic [DIGITS:0]       w_zero_from;
    logic [3:0]            w_nib;
    logic                  w_dot;
    logic                  w_blank;
    logic [DIGITS-1:0]     w_onehot;
    logic [6:0]            w_seg_raw;
    logic [DIGITS-1:0]     w_sel_raw;
    logic                  w_dp_raw;

    logic [6:0]            r_segments;
    logic                  r_dp;
    logic [DIGITS-1:0]     r_select;
    logic                  r_frame_done;

    ssds_scan_timer #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .IW           (IW)
    ) u_timer (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_idx         (w_idx),
        .o_frame_start (w_frame_start),
        .o_drive_phase (w_drive_phase)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_value <= '0;
            r_sh_dots  <= '0;
            r_sh_bz    <= 1'b0;
        end else if (w_frame_start) begin
            r_sh_value <= i_value;
            r_sh_dots  <= i_dots;
            r_sh_bz    <= i_blank_zeros;
        end
    end

    // w_zero_from[i]: shadow nibbles i..DIGITS-1 are all zero.
    assign w_zero_from[DIGITS] = 1'b1;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero
        assign w_zero_from[gi] = w_zero_from[gi+1] & (r_sh_value[4*gi +: 4] == 4'h0);
    end

    always_comb begin
        w_nib    = 4'h0;
        w_dot    = 1'b0;
        w_blank  = 1'b0;
        w_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx == IW'(i)) begin
                w_nib       = r_sh_value[4*i +: 4];
                w_dot       = r_sh_dots[i];
                w_blank     = (i != 0) && r_sh_bz && w_zero_from[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_seg_raw = SSDS_SEG_BLANK;
        w_sel_raw = '0;
        w_dp_raw  = 1'b0;
        if (i_enable) begin
            w_seg_raw = w_blank ? SSDS_SEG_BLANK : ssds_glyph(w_nib);
            w_dp_raw  = w_dot;
            if (w_drive_phase) w_sel_raw = w_onehot;
        end
    end

    // Registers hold pin-level values so reset lands directly on the inactive level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_segments   <= {7{SEG_POL}};
            r_dp         <= SEG_POL;
            r_select     <= {DIGITS{SEL_POL}};
            r_frame_done <= 1'b0;
        end else begin
            r_segments   <= w_seg_raw ^ {7{SEG_POL}};
            r_dp         <= w_dp_raw ^ SEG_POL;
            r_select     <= w_sel_raw ^ {DIGITS{SEL_POL}};
            r_frame_done <= w_frame_start;
        end
    end

    assign o_segments   = r_segments;
    assign o_dp         = r_dp;
    assign o_select     = r_select;
    assign o_frame_done = r_frame_done;

endmodule
